// File: rtl/rca_fault_detector.sv
// BIST sweep for a WIDTH-bit ripple-carry adder. It drives a fixed vector set,
// counts per-stage sum/carry mismatches and latches saturating-count fault flags.
module rca_fault_detector #(
  parameter int WIDTH  = 4,
  parameter int THRESH = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] obs_s,
  input  logic [WIDTH-1:0] obs_c,
  output logic             tv_en,
  output logic [WIDTH-1:0] tv_a,
  output logic [WIDTH-1:0] tv_b,
  output logic             tv_cin,
  output logic [WIDTH-1:0] sf,
  output logic [WIDTH-1:0] cf,
  output logic             busy,
  output logic             done,
  output logic             flags_valid
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_APPLY = 2'd1;
  localparam logic [1:0]       ST_FLAG  = 2'd2;
  localparam logic [WIDTH-1:0] K_LAST   = {WIDTH{1'b1}};
  localparam logic [1:0]       THR      = THRESH[1:0];
  localparam logic [1:0]       CNT_MAX  = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_tv_a;
  logic [WIDTH-1:0] r_tv_b;
  logic             r_tv_cin;
  logic             r_tv_en;
  logic [WIDTH-1:0] r_sf;
  logic [WIDTH-1:0] r_cf;
  logic             r_busy;
  logic             r_done;
  logic             r_flags_valid;

  logic [WIDTH-1:0] w_k_next;
  logic [WIDTH-1:0] w_exp_s;
  logic [WIDTH-1:0] w_exp_c;
  logic [WIDTH-1:0] w_mis_s;
  logic [WIDTH-1:0] w_mis_c;
  logic [WIDTH-1:0] w_sf_hit;
  logic [WIDTH-1:0] w_cf_hit;
  logic             w_clear;
  logic             w_count;

  // Packed as {cin, b, a}; b is k rotated right by one, cin is the MSB of k.
  function automatic logic [2*WIDTH:0] vector_of(input logic [WIDTH-1:0] k);
    return {k[WIDTH-1], k[0], k[WIDTH-1:1], k};
  endfunction

  // Golden ripple response to the vector currently held on tv_*.
  always_comb begin : p_golden
    logic c_run;
    w_exp_s = '0;
    w_exp_c = '0;
    c_run   = r_tv_cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_exp_s[i] = r_tv_a[i] ^ r_tv_b[i] ^ c_run;
      c_run      = (r_tv_a[i] & r_tv_b[i]) | (r_tv_a[i] & c_run) | (r_tv_b[i] & c_run);
      w_exp_c[i] = c_run;
    end
  end

  assign w_mis_s  = obs_s ^ w_exp_s;
  assign w_mis_c  = obs_c ^ w_exp_c;
  assign w_clear  = (r_state == ST_IDLE) && start;
  assign w_count  = (r_state == ST_APPLY);
  assign w_k_next = r_k + 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [1:0] r_scnt;
      logic [1:0] r_ccnt;

      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          r_scnt <= '0;
          r_ccnt <= '0;
        end else if (w_clear) begin
          r_scnt <= '0;
          r_ccnt <= '0;
        end else if (w_count) begin
          if (w_mis_s[gi] && (r_scnt != CNT_MAX)) r_scnt <= r_scnt + 2'd1;
          if (w_mis_c[gi] && (r_ccnt != CNT_MAX)) r_ccnt <= r_ccnt + 2'd1;
        end
      end

      assign w_sf_hit[gi] = (r_scnt >= THR);
      assign w_cf_hit[gi] = (r_ccnt >= THR);
    end
  endgenerate

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state       <= ST_IDLE;
      r_k           <= '0;
      r_tv_a        <= '0;
      r_tv_b        <= '0;
      r_tv_cin      <= 1'b0;
      r_tv_en       <= 1'b0;
      r_sf          <= '0;
      r_cf          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_flags_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state                    <= ST_APPLY;
            r_k                        <= '0;
            {r_tv_cin, r_tv_b, r_tv_a} <= vector_of('0);
            r_tv_en                    <= 1'b1;
            r_busy                     <= 1'b1;
          end
        end
        ST_APPLY: begin
          if (r_k == K_LAST) begin
            r_state  <= ST_FLAG;
            r_k      <= '0;
            r_tv_a   <= '0;
            r_tv_b   <= '0;
            r_tv_cin <= 1'b0;
            r_tv_en  <= 1'b0;
          end else begin
            r_k                        <= w_k_next;
            {r_tv_cin, r_tv_b, r_tv_a} <= vector_of(w_k_next);
          end
        end
        ST_FLAG: begin
          r_sf          <= w_sf_hit;
          r_cf          <= w_cf_hit;
          r_done        <= 1'b1;
          r_flags_valid <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tv_en       = r_tv_en;
  assign tv_a        = r_tv_a;
  assign tv_b        = r_tv_b;
  assign tv_cin      = r_tv_cin;
  assign sf          = r_sf;
  assign cf          = r_cf;
  assign busy        = r_busy;
  assign done        = r_done;
  assign flags_valid = r_flags_valid;

endmodule

// File: tb/tb_rca_fault_detector.sv
// Bench for rca_fault_detector: two instances (THRESH=2 and THRESH=1) each see a
// behavioural adder with injectable faults; flags are checked against a sweep model.
module tb_rca_fault_detector;

  localparam int W  = 4;
  localparam int NV = 1 << W;
  localparam int NT = 40;

  logic clk, clr, start;
  logic [W-1:0] obs_s0, obs_c0, tv_a0, tv_b0, sf0, cf0;
  logic         tv_en0, tv_cin0, busy0, done0, fv0;
  logic [W-1:0] obs_s1, obs_c1, tv_a1, tv_b1, sf1, cf1;
  logic         tv_en1, tv_cin1, busy1, done1, fv1;

  logic [W-1:0] f_s_and, f_s_or, f_c_and, f_c_or, f_g_vec, f_g_mask;
  logic         f_g_en;

  int n_cmp = 0;
  int n_bad = 0;

  logic         tr_en[NT], tr_busy[NT], tr_done[NT], tr_done1[NT], tr_cin[NT], tr_fv[NT];
  logic [W-1:0] tr_a[NT], tr_b[NT], tr_sf[NT], tr_cf[NT], tr_sf1[NT], tr_cf1[NT];

  // Per-stage sums and carries by plain integer addition of the low i+1 bits.
  function automatic logic [2*W-1:0] golden_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic cin);
    logic [W-1:0] s, c;
    int sum_full, m, part;
    sum_full = int'(a) + int'(b) + int'(cin);
    s = W'(sum_full);
    c = '0;
    for (int i = 0; i < W; i++) begin
      m    = (1 << (i + 1)) - 1;
      part = (int'(a) & m) + (int'(b) & m) + int'(cin);
      c[i] = part[i+1];
    end
    return {c, s};
  endfunction

  function automatic logic [2*W-1:0] fault_adder(
      input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
      input logic [W-1:0] s_and, input logic [W-1:0] s_or,
      input logic [W-1:0] c_and, input logic [W-1:0] c_or,
      input logic g_en, input logic [W-1:0] g_vec, input logic [W-1:0] g_mask);
    logic [W-1:0] s, c;
    {c, s} = golden_add(a, b, cin);
    s = (s & s_and) | s_or;
    c = (c & c_and) | c_or;
    if (g_en && (a == g_vec)) s = s ^ g_mask;
    return {c, s};
  endfunction

  // Expected {cf, sf} after a full sweep with the current fault set.
  function automatic logic [2*W-1:0] ref_flags(input int thresh);
    int cs[W];
    int cc[W];
    logic [W-1:0] a, b, sfr, cfr;
    logic cin;
    logic [2*W-1:0] g, o;
    for (int i = 0; i < W; i++) begin
      cs[i] = 0;
      cc[i] = 0;
    end
    for (int k = 0; k < NV; k++) begin
      a   = W'(k);
      b   = W'((k >> 1) | ((k & 1) << (W - 1)));
      cin = a[W-1];
      g   = golden_add(a, b, cin);
      o   = fault_adder(a, b, cin, f_s_and, f_s_or, f_c_and, f_c_or, f_g_en, f_g_vec, f_g_mask);
      for (int i = 0; i < W; i++) begin
        if (o[i] !== g[i] && cs[i] < 3) cs[i]++;
        if (o[W+i] !== g[W+i] && cc[i] < 3) cc[i]++;
      end
    end
    for (int i = 0; i < W; i++) begin
      sfr[i] = (cs[i] >= thresh);
      cfr[i] = (cc[i] >= thresh);
    end
    return {cfr, sfr};
  endfunction

  assign {obs_c0, obs_s0} = fault_adder(tv_a0, tv_b0, tv_cin0, f_s_and, f_s_or, f_c_and, f_c_or,
                                        f_g_en, f_g_vec, f_g_mask);
  assign {obs_c1, obs_s1} = fault_adder(tv_a1, tv_b1, tv_cin1, f_s_and, f_s_or, f_c_and, f_c_or,
                                        f_g_en, f_g_vec, f_g_mask);

  rca_fault_detector #(.WIDTH(W), .THRESH(2)) u_dut (
    .clk(clk), .clr(clr), .start(start), .obs_s(obs_s0), .obs_c(obs_c0),
    .tv_en(tv_en0), .tv_a(tv_a0), .tv_b(tv_b0), .tv_cin(tv_cin0),
    .sf(sf0), .cf(cf0), .busy(busy0), .done(done0), .flags_valid(fv0));

  rca_fault_detector #(.WIDTH(W), .THRESH(1)) u_dut_t1 (
    .clk(clk), .clr(clr), .start(start), .obs_s(obs_s1), .obs_c(obs_c1),
    .tv_en(tv_en1), .tv_a(tv_a1), .tv_b(tv_b1), .tv_cin(tv_cin1),
    .sf(sf1), .cf(cf1), .busy(busy1), .done(done1), .flags_valid(fv1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_faults();
    f_s_and = '1; f_s_or = '0; f_c_and = '1; f_c_or = '0;
    f_g_en = 1'b0; f_g_vec = '0; f_g_mask = '0;
  endtask

  task automatic sample(input int j);
    tr_en[j] = tv_en0;   tr_busy[j] = busy0; tr_done[j] = done0; tr_done1[j] = done1;
    tr_cin[j] = tv_cin0; tr_fv[j] = fv0;     tr_a[j] = tv_a0;    tr_b[j] = tv_b0;
    tr_sf[j] = sf0;      tr_cf[j] = cf0;     tr_sf1[j] = sf1;    tr_cf1[j] = cf1;
  endtask

  // Index j of the trace is the cycle following edge Ej (E0 samples start).
  task automatic run_sweep(input bit toggle, input int ncyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      sample(j);
      start = (toggle && j <= 16) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b0; clear_faults();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tv_en0, tv_a0, tv_b0, tv_cin0, sf0, cf0, busy0, done0, fv0} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs_t2: got %b want all zero",
               {tv_en0, tv_a0, tv_b0, tv_cin0, sf0, cf0, busy0, done0, fv0});
    end
    n_cmp++;
    if ({tv_en1, tv_a1, tv_b1, tv_cin1, sf1, cf1, busy1, done1, fv1} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs_t1: got %b want all zero",
               {tv_en1, tv_a1, tv_b1, tv_cin1, sf1, cf1, busy1, done1, fv1});
    end
    clr = 1'b1;
    @(negedge clk);
    $display("reset: released, busy=%b flags_valid=%b", busy0, fv0);
  endtask

  task automatic test_fault_free();
    int ndone;
    logic [W-1:0] ea, eb;
    logic ecin;
    clear_faults();
    run_sweep(1'b0, 20);
    for (int j = 0; j < NV; j++) begin
      ea   = W'(j);
      eb   = W'((j >> 1) | ((j & 1) << (W - 1)));
      ecin = ea[W-1];
      n_cmp++;
      if (tr_en[j] !== 1'b1 || tr_busy[j] !== 1'b1 || tr_done[j] !== 1'b0 ||
          tr_a[j] !== ea || tr_b[j] !== eb || tr_cin[j] !== ecin) begin
        n_bad++;
        $display("FAIL apply_cycle_%0d: got en=%b busy=%b done=%b a=%h b=%h cin=%b want 1 1 0 %h %h %b",
                 j, tr_en[j], tr_busy[j], tr_done[j], tr_a[j], tr_b[j], tr_cin[j], ea, eb, ecin);
      end
    end
    n_cmp++;
    if (tr_en[16] !== 1'b0 || tr_busy[16] !== 1'b1 || tr_a[16] !== '0 || tr_b[16] !== '0 ||
        tr_cin[16] !== 1'b0 || tr_done[16] !== 1'b0) begin
      n_bad++;
      $display("FAIL flag_cycle: got en=%b busy=%b a=%h b=%h cin=%b done=%b want 0 1 0 0 0 0",
               tr_en[16], tr_busy[16], tr_a[16], tr_b[16], tr_cin[16], tr_done[16]);
    end
    n_cmp++;
    if (tr_done[17] !== 1'b1 || tr_busy[17] !== 1'b0 || tr_fv[17] !== 1'b1 ||
        tr_sf[17] !== '0 || tr_cf[17] !== '0) begin
      n_bad++;
      $display("FAIL done_cycle: got done=%b busy=%b fv=%b sf=%b cf=%b want 1 0 1 0000 0000",
               tr_done[17], tr_busy[17], tr_fv[17], tr_sf[17], tr_cf[17]);
    end
    ndone = 0;
    for (int j = 0; j < 20; j++) if (tr_done[j] === 1'b1) ndone++;
    n_cmp++;
    if (ndone != 1 || tr_fv[19] !== 1'b1) begin
      n_bad++;
      $display("FAIL done_pulse_width: got %0d done cycles fv=%b want 1 and 1", ndone, tr_fv[19]);
    end
    $display("sweep fault_free: sf=%b cf=%b done_cycles=%0d", tr_sf[17], tr_cf[17], ndone);
  endtask

  task automatic test_sum_stuck0();
    logic [W-1:0] esf, ecf;
    clear_faults();
    f_s_and = 4'b1011;
    {ecf, esf} = ref_flags(2);
    run_sweep(1'b0, 20);
    n_cmp++;
    if (tr_sf[17] !== esf || tr_cf[17] !== ecf || tr_sf[17] !== 4'b0100) begin
      n_bad++;
      $display("FAIL sum_sa0_bit2: got sf=%b cf=%b want sf=%b cf=%b", tr_sf[17], tr_cf[17], esf, ecf);
    end
    $display("sweep sum_sa0_bit2: sf=%b cf=%b", tr_sf[17], tr_cf[17]);
  endtask

  task automatic test_carry_stuck1();
    logic [W-1:0] esf, ecf;
    clear_faults();
    f_c_or = 4'b1000;
    {ecf, esf} = ref_flags(2);
    run_sweep(1'b0, 20);
    n_cmp++;
    if (tr_sf[17] !== esf || tr_cf[17] !== ecf || tr_cf[17] !== 4'b1000) begin
      n_bad++;
      $display("FAIL carry_sa1_c4: got sf=%b cf=%b want sf=%b cf=%b", tr_sf[17], tr_cf[17], esf, ecf);
    end
    $display("sweep carry_sa1_c4: sf=%b cf=%b", tr_sf[17], tr_cf[17]);
  endtask

  task automatic test_glitch_thresh();
    logic [W-1:0] esf0, ecf0, esf1, ecf1;
    clear_faults();
    f_g_en = 1'b1; f_g_vec = 4'd5; f_g_mask = 4'b0001;
    {ecf0, esf0} = ref_flags(2);
    {ecf1, esf1} = ref_flags(1);
    run_sweep(1'b0, 20);
    n_cmp++;
    if (tr_sf[17] !== esf0 || tr_cf[17] !== ecf0) begin
      n_bad++;
      $display("FAIL glitch_thresh2: got sf=%b cf=%b want sf=%b cf=%b", tr_sf[17], tr_cf[17], esf0, ecf0);
    end
    n_cmp++;
    if (tr_sf1[17] !== esf1 || tr_cf1[17] !== ecf1) begin
      n_bad++;
      $display("FAIL glitch_thresh1: got sf=%b cf=%b want sf=%b cf=%b", tr_sf1[17], tr_cf1[17], esf1, ecf1);
    end
    $display("sweep glitch_v5: thr2 sf=%b thr1 sf=%b", tr_sf[17], tr_sf1[17]);
  endtask

  task automatic test_start_during_apply();
    logic [W-1:0] esf, ecf;
    int ndone;
    clear_faults();
    f_s_and = 4'b1101; f_c_or = 4'b0001;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) f_c_or = '0;
      {ecf, esf} = ref_flags(2);
      run_sweep(1'b1, 20);
      ndone = 0;
      for (int j = 0; j < 20; j++) if (tr_done[j] === 1'b1) ndone++;
      n_cmp++;
      if (ndone != 1 || tr_done[17] !== 1'b1 || tr_en[15] !== 1'b1 || tr_en[16] !== 1'b0) begin
        n_bad++;
        $display("FAIL start_toggle_len_p%0d: got %0d done, done17=%b en15=%b en16=%b want 1 1 1 0",
                 pass, ndone, tr_done[17], tr_en[15], tr_en[16]);
      end
      n_cmp++;
      if (tr_sf[17] !== esf || tr_cf[17] !== ecf) begin
        n_bad++;
        $display("FAIL start_toggle_flags_p%0d: got sf=%b cf=%b want sf=%b cf=%b",
                 pass, tr_sf[17], tr_cf[17], esf, ecf);
      end
      $display("sweep start_toggle pass %0d: sf=%b cf=%b done_cycles=%0d", pass, tr_sf[17], tr_cf[17], ndone);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] esf_a, ecf_a, esf_b, ecf_b;
    int ndone;
    clear_faults();
    f_s_and = W'($urandom); f_c_or = W'($urandom);
    {ecf_a, esf_a} = ref_flags(2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < NT; j++) begin
      @(negedge clk);
      sample(j);
      if (j == 17) begin
        clear_faults();
        f_s_or = W'($urandom); f_c_and = W'($urandom);
        {ecf_b, esf_b} = ref_flags(2);
      end
      if (j >= 18) start = 1'b0;
    end
    ndone = 0;
    for (int j = 0; j < NT; j++) if (tr_done[j] === 1'b1) ndone++;
    n_cmp++;
    if (ndone != 2 || tr_done[17] !== 1'b1 || tr_done[35] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_done_timing: got %0d done, d17=%b d35=%b want 2 1 1", ndone, tr_done[17], tr_done[35]);
    end
    n_cmp++;
    if (tr_en[17] !== 1'b0 || tr_busy[17] !== 1'b0 || tr_en[18] !== 1'b1 || tr_a[18] !== '0 ||
        tr_busy[18] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_idle_gap: got en17=%b busy17=%b en18=%b a18=%h busy18=%b want 0 0 1 0 1",
               tr_en[17], tr_busy[17], tr_en[18], tr_a[18], tr_busy[18]);
    end
    n_cmp++;
    if (tr_sf[17] !== esf_a || tr_cf[17] !== ecf_a || tr_sf[34] !== esf_a || tr_cf[34] !== ecf_a) begin
      n_bad++;
      $display("FAIL b2b_first_flags: got sf=%b cf=%b held sf=%b cf=%b want sf=%b cf=%b",
               tr_sf[17], tr_cf[17], tr_sf[34], tr_cf[34], esf_a, ecf_a);
    end
    n_cmp++;
    if (tr_sf[35] !== esf_b || tr_cf[35] !== ecf_b) begin
      n_bad++;
      $display("FAIL b2b_second_flags: got sf=%b cf=%b want sf=%b cf=%b", tr_sf[35], tr_cf[35], esf_b, ecf_b);
    end
    $display("sweep back_to_back: first sf=%b cf=%b second sf=%b cf=%b",
             tr_sf[17], tr_cf[17], tr_sf[35], tr_cf[35]);
  endtask

  task automatic test_random_faults();
    logic [W-1:0] esf0, ecf0, esf1, ecf1;
    for (int n = 0; n < 5; n++) begin
      f_s_and = W'($urandom) | W'($urandom); f_s_or = W'($urandom) & W'($urandom);
      f_c_and = W'($urandom) | W'($urandom); f_c_or = W'($urandom) & W'($urandom);
      f_g_en = 1'($urandom_range(0, 1)); f_g_vec = W'($urandom); f_g_mask = W'($urandom);
      {ecf0, esf0} = ref_flags(2);
      {ecf1, esf1} = ref_flags(1);
      run_sweep(1'b0, 20);
      n_cmp++;
      if (tr_sf[17] !== esf0 || tr_cf[17] !== ecf0 || tr_sf1[17] !== esf1 || tr_cf1[17] !== ecf1) begin
        n_bad++;
        $display("FAIL random_%0d: got t2 sf=%b cf=%b t1 sf=%b cf=%b want t2 %b %b t1 %b %b",
                 n, tr_sf[17], tr_cf[17], tr_sf1[17], tr_cf1[17], esf0, ecf0, esf1, ecf1);
      end
      $display("sweep random %0d: t2 sf=%b cf=%b t1 sf=%b cf=%b", n, tr_sf[17], tr_cf[17],
               tr_sf1[17], tr_cf1[17]);
    end
  endtask

  task automatic test_clr_mid_sweep();
    logic [W-1:0] esf, ecf;
    clear_faults();
    f_s_or = 4'b0010;
    run_sweep(1'b0, 20);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 clr = 1'b0;
    #1;
    n_cmp++;
    if ({tv_en0, tv_a0, tv_b0, tv_cin0, sf0, cf0, busy0, done0, fv0,
         tv_en1, tv_a1, tv_b1, tv_cin1, sf1, cf1, busy1, done1, fv1} !== '0) begin
      n_bad++;
      $display("FAIL clr_mid_sweep: got t2 %b t1 %b want all zero",
               {tv_en0, tv_a0, tv_b0, tv_cin0, sf0, cf0, busy0, done0, fv0},
               {tv_en1, tv_a1, tv_b1, tv_cin1, sf1, cf1, busy1, done1, fv1});
    end
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (fv0 !== 1'b0 || sf0 !== '0 || busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_after_release: got fv=%b sf=%b busy=%b want 0 0000 0", fv0, sf0, busy0);
    end
    clear_faults();
    f_c_and = 4'b1101;
    {ecf, esf} = ref_flags(2);
    run_sweep(1'b0, 20);
    n_cmp++;
    if (tr_done[17] !== 1'b1 || tr_fv[16] !== 1'b0 || tr_fv[17] !== 1'b1 ||
        tr_sf[17] !== esf || tr_cf[17] !== ecf) begin
      n_bad++;
      $display("FAIL clr_restart: got done=%b fv16=%b fv17=%b sf=%b cf=%b want 1 0 1 %b %b",
               tr_done[17], tr_fv[16], tr_fv[17], tr_sf[17], tr_cf[17], esf, ecf);
    end
    $display("sweep after clr: sf=%b cf=%b flags_valid=%b", tr_sf[17], tr_cf[17], tr_fv[17]);
  endtask

  initial begin
    clr = 1'b0;
    start = 1'b0;
    clear_faults();
    test_reset();
    test_fault_free();
    test_sum_stuck0();
    test_carry_stuck1();
    test_glitch_thresh();
    test_start_during_apply();
    test_back_to_back();
    test_random_faults();
    test_clr_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
